// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage hazard bus between decode and the forwarding/hazard controller.
// Decode drives the instruction fields, the controller returns mux selects and stall.
interface fwd_hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_we;
  logic              id_is_load;
  logic              id_is_mac;
  logic              flush;
  logic [2:0]        fwd_sel_a;
  logic [2:0]        fwd_sel_b;
  logic              stall;
  logic              mac_done;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_we, id_is_load, id_is_mac, flush,
    input  fwd_sel_a, fwd_sel_b, stall, mac_done
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_we, id_is_load, id_is_mac, flush,
    output fwd_sel_a, fwd_sel_b, stall, mac_done
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for the 5-stage pipeline with a multi-cycle MAC.
// Tracks EX/MEM/WB destination tags plus the in-flight MAC destination and turns
// them into operand forwarding selects and an ID-stage stall.
module fwd_hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int MAC_LAT = 3
) (
  input logic             clk,
  input logic             rst_n,
  fwd_hazard_ctrl_if.slave bus
);

  localparam int CW = $clog2(MAC_LAT + 1);

  localparam logic [2:0] SEL_RF  = 3'b000;
  localparam logic [2:0] SEL_EX  = 3'b001;
  localparam logic [2:0] SEL_MEM = 3'b010;
  localparam logic [2:0] SEL_WB  = 3'b011;
  localparam logic [2:0] SEL_MAC = 3'b100;

  logic              ex_valid, mem_valid, wb_valid;
  logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
  logic              ex_load, mem_load, wb_load;
  logic [CW-1:0]     mac_cnt;
  logic [REG_AW-1:0] mac_rd;

  logic [3:0] res_a;
  logic [3:0] res_b;
  logic       mac_busy;
  logic       struct_haz;
  logic       waw_haz;
  logic       stall_int;
  logic       issue;

  // Resolve one source operand to {stall_cause, select}; youngest producer wins.
  // A stall cause leaves the select at regfile since EX discards it anyway.
  function automatic logic [3:0] resolve_src(input logic use_src,
                                             input logic [REG_AW-1:0] src);
    logic [3:0] r;
    r = {1'b0, SEL_RF};
    if (use_src && (src != '0)) begin
      if ((mac_cnt != '0) && (mac_rd == src)) begin
        r = (mac_cnt == CW'(1)) ? {1'b0, SEL_MAC} : {1'b1, SEL_RF};
      end else if (ex_valid && (ex_rd == src)) begin
        r = ex_load ? {1'b1, SEL_RF} : {1'b0, SEL_EX};
      end else if (mem_valid && (mem_rd == src)) begin
        r = {1'b0, SEL_MEM};
      end else if (wb_valid && (wb_rd == src)) begin
        r = {1'b0, SEL_WB};
      end
    end
    return r;
  endfunction

  // Combine operand, structural and WAW hazards into the ID stall and issue strobe.
  always_comb begin
    res_a      = resolve_src(bus.id_use_rs1, bus.id_rs1);
    res_b      = resolve_src(bus.id_use_rs2, bus.id_rs2);
    mac_busy   = (mac_cnt > CW'(1));
    struct_haz = bus.id_is_mac & mac_busy;
    waw_haz    = (bus.id_we | bus.id_is_mac) & (bus.id_rd == mac_rd) &
                 (bus.id_rd != '0) & mac_busy;
    stall_int  = bus.id_valid & ~bus.flush &
                 (res_a[3] | res_b[3] | struct_haz | waw_haz);
    issue      = bus.id_valid & ~stall_int & ~bus.flush;
  end

  assign bus.fwd_sel_a = res_a[2:0];
  assign bus.fwd_sel_b = res_b[2:0];
  assign bus.stall     = stall_int;
  assign bus.mac_done  = (mac_cnt == CW'(1));

  // Advance the tag pipeline and the MAC countdown; stalled or flushed slots become bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid  <= 1'b0;
      ex_rd     <= '0;
      ex_load   <= 1'b0;
      mem_valid <= 1'b0;
      mem_rd    <= '0;
      mem_load  <= 1'b0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_load   <= 1'b0;
      mac_cnt   <= '0;
      mac_rd    <= '0;
    end else begin
      wb_valid  <= mem_valid;
      wb_rd     <= mem_rd;
      wb_load   <= mem_load;
      mem_valid <= ex_valid;
      mem_rd    <= ex_rd;
      mem_load  <= ex_load;
      ex_valid  <= issue & bus.id_we & ~bus.id_is_mac;
      ex_rd     <= bus.id_rd;
      ex_load   <= bus.id_is_load;
      if (issue && bus.id_is_mac) begin
        mac_cnt <= CW'(MAC_LAT);
        mac_rd  <= bus.id_rd;
      end else if (mac_cnt != '0) begin
        mac_cnt <= mac_cnt - CW'(1);
      end
    end
  end

endmodule
